// File: rtl/mdu_unit_if.sv
// Bus between the core's register-file ports and the RV32M multiply/divide unit.
//   master (core side): drives start, funct3, RU_rs1, RU_rs2, rd_in;
//                       observes busy, rd_out, DataWr, RUWr.
//   slave  (mdu side) : the reverse.
interface mdu_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] RU_rs1;
    logic [XLEN-1:0] RU_rs2;
    logic [4:0]      rd_in;
    logic            busy;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] DataWr;
    logic            RUWr;

    modport master (
        output start, funct3, RU_rs1, RU_rs2, rd_in,
        input  busy, rd_out, DataWr, RUWr
    );

    modport slave (
        input  start, funct3, RU_rs1, RU_rs2, rd_in,
        output busy, rd_out, DataWr, RUWr
    );
endinterface

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mdu_unit_if.slave
//              in : start, funct3, RU_rs1, RU_rs2, rd_in
//              out: busy, rd_out, DataWr, RUWr (registered, one-cycle write strobe)
// Multiply: shift-add on magnitudes, XLEN cycles. Divide: restoring, XLEN cycles.
// Divide-by-zero and signed overflow are resolved at acceptance (FAST path).
// Build option MDU_FAST_MUL_EN: products are formed combinationally in the FAST
// state and the iterative multiply state is not built.
module mdu_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

`ifdef MDU_FAST_MUL_EN
    typedef enum logic [2:0] {S_IDLE, S_DIV, S_FAST, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FAST, S_DONE} state_e;
`endif

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    // acc: {hi, lo}. Multiply: {partial product hi, multiplier}. Divide: {remainder, quotient}.
    logic [PW-1:0]    acc_q,     acc_d;
    logic [XLEN-1:0]  opb_q,     opb_d;
    logic [2:0]       funct3_q,  funct3_d;
    logic [4:0]       rd_q,      rd_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q,    busy_d;
    logic             ruwr_q,    ruwr_d;
    logic [XLEN-1:0]  data_q,    data_d;
    logic [4:0]       rd_out_q,  rd_out_d;

    logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c, fast_val_c;
    logic            div_zero_c, div_ovf_c;
    logic [XLEN:0]   div_shift_c, div_diff_c;
    logic [PW-1:0]   div_next_c;
`ifdef MDU_FAST_MUL_EN
    logic [PW-1:0]   prod_c;
`else
    logic [XLEN:0]   mul_sum_c;
    logic [PW-1:0]   mul_next_c;
`endif

    // Sign-correct the magnitude result and pick the field funct3 asks for.
    function automatic logic [XLEN-1:0] final_result(input logic [2:0]    f3,
                                                     input logic [PW-1:0] acc,
                                                     input logic          neg_res,
                                                     input logic          neg_rem);
        logic [PW-1:0]   p;
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        p = neg_res ? -acc : acc;
        q = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = neg_rem ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
        if (!f3[2]) begin
            final_result = (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
        end else begin
            final_result = f3[1] ? r : q;
        end
    endfunction

    // Operand decode at acceptance: signedness, magnitudes and special cases.
    always_comb begin
        a_signed_c = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed_c = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_neg_c    = a_signed_c && bus.RU_rs1[XLEN-1];
        b_neg_c    = b_signed_c && bus.RU_rs2[XLEN-1];
        a_mag_c    = a_neg_c ? -bus.RU_rs1 : bus.RU_rs1;
        b_mag_c    = b_neg_c ? -bus.RU_rs2 : bus.RU_rs2;
        div_zero_c = bus.funct3[2] && (bus.RU_rs2 == '0);
        div_ovf_c  = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.RU_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.RU_rs2 == '1);
        if (div_zero_c) begin
            fast_val_c = bus.funct3[1] ? bus.RU_rs1 : '1;
        end else begin
            // overflow: quotient is the dividend itself, remainder is zero
            fast_val_c = bus.funct3[1] ? '0 : bus.RU_rs1;
        end
    end

    // One iteration step of each datapath.
    always_comb begin
        div_shift_c = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, opb_q};
        div_next_c  = {(div_diff_c[XLEN] ? div_shift_c[XLEN-1:0] : div_diff_c[XLEN-1:0]),
                       acc_q[XLEN-2:0], ~div_diff_c[XLEN]};
`ifdef MDU_FAST_MUL_EN
        prod_c      = PW'(acc_q[XLEN-1:0]) * PW'(opb_q);
`else
        mul_sum_c   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_next_c  = {mul_sum_c, acc_q[XLEN-1:1]};
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        ruwr_d    = 1'b0;
        data_d    = data_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    funct3_d  = bus.funct3;
                    rd_d      = bus.rd_in;
                    busy_d    = 1'b1;
                    counter_d = '0;
                    neg_res_d = a_neg_c ^ b_neg_c;
                    neg_rem_d = a_neg_c;
                    opb_d     = b_mag_c;
                    acc_d     = {{XLEN{1'b0}}, a_mag_c};
                    if (div_zero_c || div_ovf_c) begin
                        acc_d   = {{XLEN{1'b0}}, fast_val_c};
                        state_d = S_FAST;
                    end else if (!bus.funct3[2]) begin
`ifdef MDU_FAST_MUL_EN
                        state_d = S_FAST;
`else
                        state_d = S_MUL;
`endif
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
`ifndef MDU_FAST_MUL_EN
            S_MUL: begin
                acc_d     = mul_next_c;
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(XLEN - 1)) begin
                    counter_d = '0;
                    state_d   = S_DONE;
                    data_d    = final_result(funct3_q, mul_next_c, neg_res_q, neg_rem_q);
                    rd_out_d  = rd_q;
                    ruwr_d    = (rd_q != 5'd0);
                end
            end
`endif
            S_DIV: begin
                acc_d     = div_next_c;
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(XLEN - 1)) begin
                    counter_d = '0;
                    state_d   = S_DONE;
                    data_d    = final_result(funct3_q, div_next_c, neg_res_q, neg_rem_q);
                    rd_out_d  = rd_q;
                    ruwr_d    = (rd_q != 5'd0);
                end
            end
            S_FAST: begin
`ifdef MDU_FAST_MUL_EN
                data_d = funct3_q[2] ? acc_q[XLEN-1:0]
                                     : final_result(funct3_q, prod_c, neg_res_q, neg_rem_q);
`else
                data_d = acc_q[XLEN-1:0];
`endif
                state_d  = S_DONE;
                rd_out_d = rd_q;
                ruwr_d   = (rd_q != 5'd0);
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            ruwr_q    <= 1'b0;
            data_q    <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            ruwr_q    <= ruwr_d;
            data_q    <= data_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.RUWr   = ruwr_q;
    assign bus.DataWr = data_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, special cases, ignored starts,
// rd=0 suppression, back-to-back issue and asynchronous reset abort.
module tb_mdu_unit;
    localparam int XL = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mdu_unit_if #(.XLEN(XL)) bus ();
    mdu_unit #(.XLEN(XL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Issue one request and watch up to max_cyc cycles after acceptance (cycle k = E+k).
    // glitch_cyc > 0: pulse start with other operands in that cycle; toggle: flip RU_rs1 every cycle.
    task automatic issue_and_watch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input int max_cyc, input int glitch_cyc,
                                   input bit toggle,
                                   output int wr_cyc, output int n_str, output logic [31:0] wr_data,
                                   output logic [4:0] wr_rd, output int busy_cnt, output int busy_last,
                                   output logic [31:0] done_data);
        wr_cyc = -1; n_str = 0; wr_data = '0; wr_rd = '0; busy_cnt = 0; busy_last = -1; done_data = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.RU_rs1 = a; bus.RU_rs2 = b; bus.rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (bus.busy === 1'b1) begin
                busy_cnt++; busy_last = k; done_data = bus.DataWr;
            end
            if (bus.RUWr === 1'b1) begin
                n_str++; wr_cyc = k; wr_data = bus.DataWr; wr_rd = bus.rd_out;
            end
            if (k == glitch_cyc) begin
                bus.start = 1'b1; bus.funct3 = 3'b101; bus.RU_rs1 = 32'd9; bus.RU_rs2 = 32'd0; bus.rd_in = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (toggle) bus.RU_rs1 = ~bus.RU_rs1;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.RUWr !== 1'b0) begin errors++; $display("FAIL reset_ruwr got %b exp 0", bus.RUWr); end
        checks++; if (bus.DataWr !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.DataWr); end
        checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", bus.rd_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int wc, ns, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        issue_and_watch(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != MUL_LAT) begin errors++; $display("FAIL mul_latency got %0d exp %0d", wc, MUL_LAT); end
        checks++; if (ns != 1) begin errors++; $display("FAIL mul_strobes got %0d exp 1", ns); end
        checks++; if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data got %h exp ffffffeb", d); end
        checks++; if (r !== 5'd5) begin errors++; $display("FAIL mul_rd got %0d exp 5", r); end
        checks++; if (bc != MUL_LAT || bl != MUL_LAT) begin
            errors++; $display("FAIL mul_busy got cnt %0d last %0d exp %0d", bc, bl, MUL_LAT); end
    endtask

    task automatic test_mulh();
        int wc, ns, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        issue_and_watch(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != MUL_LAT || d !== 32'h4000_0000) begin
            errors++; $display("FAIL mulh got %h at %0d exp 40000000 at %0d", d, wc, MUL_LAT); end
        issue_and_watch(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL mulhu got %h exp 40000000", d); end
        issue_and_watch(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h exp ffffffff", d); end
        issue_and_watch(3'b000, 32'd0, 32'h1234_5678, 5'd4, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != MUL_LAT || d !== 32'd0) begin
            errors++; $display("FAIL mul_zero got %h at %0d exp 0 at %0d", d, wc, MUL_LAT); end
    endtask

    task automatic test_fast_div();
        int wc, ns, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        issue_and_watch(3'b101, 32'd100, 32'd0, 5'd6, 10, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 2 || d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_zero got %h at %0d exp ffffffff at 2", d, wc); end
        checks++; if (bc != 2 || bl != 2) begin errors++; $display("FAIL fast_busy got cnt %0d last %0d exp 2", bc, bl); end
        issue_and_watch(3'b111, 32'd100, 32'd0, 5'd6, 10, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 2 || d !== 32'd100) begin errors++; $display("FAIL remu_zero got %h at %0d exp 64 at 2", d, wc); end
        issue_and_watch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 10, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 2 || d !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h at %0d exp 80000000 at 2", d, wc); end
        issue_and_watch(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 10, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 2 || d !== 32'd0) begin errors++; $display("FAIL rem_ovf got %h at %0d exp 0 at 2", d, wc); end
    endtask

    task automatic test_div();
        int wc, ns, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        issue_and_watch(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 33 || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_signed got %h at %0d exp ffffffff at 33", d, wc); end
        issue_and_watch(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (wc != 33 || d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_signed got %h at %0d exp fffffffd at 33", d, wc); end
        issue_and_watch(3'b101, 32'd100, 32'd7, 5'd8, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu got %h exp e", d); end
        issue_and_watch(3'b111, 32'd100, 32'd7, 5'd8, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu got %h exp 2", d); end
    endtask

    task automatic test_ignore_and_rd0();
        int wc, ns, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        issue_and_watch(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 40, 5, 1'b1, wc, ns, d, r, bc, bl, dd);
        checks++; if (ns != 1 || d !== 32'hFFFF_FFEB || r !== 5'd5) begin
            errors++; $display("FAIL ignore_start got n %0d data %h rd %0d exp 1 ffffffeb 5", ns, d, r); end
        issue_and_watch(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd0, 40, 0, 1'b0, wc, ns, d, r, bc, bl, dd);
        checks++; if (ns != 0) begin errors++; $display("FAIL rd0_strobe got %0d exp 0", ns); end
        checks++; if (bl != 33 || dd !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL rd0_data got %h last %0d exp fffffffd 33", dd, bl); end
    endtask

    task automatic test_back_to_back();
        int w1, w2; logic [31:0] d1, d2;
        w1 = -1; w2 = -1; d1 = '0; d2 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.RU_rs1 = 32'd5; bus.RU_rs2 = 32'd0; bus.rd_in = 5'd3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.RUWr === 1'b1) begin
                if (w1 < 0) begin w1 = k; d1 = bus.DataWr; end
                else begin w2 = k; d2 = bus.DataWr; end
            end
            if (k == 3) begin
                bus.start = 1'b1; bus.funct3 = 3'b111; bus.RU_rs1 = 32'd9; bus.RU_rs2 = 32'd0; bus.rd_in = 5'd4;
            end
        end
        checks++; if (w1 != 2 || d1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_first got %h at %0d exp ffffffff at 2", d1, w1); end
        checks++; if (w2 != 5 || d2 !== 32'd9) begin errors++; $display("FAIL b2b_second got %h at %0d exp 9 at 5", d2, w2); end
    endtask

    task automatic test_reset_abort();
        int ns, bh, wc, n2, bc, bl; logic [31:0] d, dd; logic [4:0] r;
        ns = 0; bh = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.RU_rs1 = 32'd100; bus.RU_rs2 = 32'd7; bus.rd_in = 5'd12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.RUWr !== 1'b0 || bus.DataWr !== 32'd0) begin
            errors++; $display("FAIL abort_outputs got busy %b ruwr %b data %h exp 0 0 0", bus.busy, bus.RUWr, bus.DataWr); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.RUWr === 1'b1) ns++;
            if (bus.busy === 1'b1) bh++;
        end
        checks++; if (ns != 0 || bh != 0) begin errors++; $display("FAIL abort_no_strobe got strobes %0d busy %0d exp 0 0", ns, bh); end
        issue_and_watch(3'b101, 32'd100, 32'd7, 5'd12, 40, 0, 1'b0, wc, n2, d, r, bc, bl, dd);
        checks++; if (wc != 33 || d !== 32'd14 || r !== 5'd12) begin
            errors++; $display("FAIL after_abort got %h rd %0d at %0d exp e 12 at 33", d, r, wc); end
    endtask

    initial begin
        bus.start = 1'b0; bus.funct3 = '0; bus.RU_rs1 = '0; bus.RU_rs2 = '0; bus.rd_in = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_fast_div();
        test_div();
        test_ignore_and_rd0();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
